// File: rtl/uart_fifo_param.sv
// Parametrised synchronous FIFO for the UART TX/RX paths with level, thresholds and sticky errors.
// Define UART_FIFO_FWFT_EN for first-word fall-through reads; default is a registered read.
module uart_fifo_param #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned AF_THRESH = DEPTH - 2,
   parameter int unsigned AE_THRESH = 2
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_clr,
   input  logic [DATA_W-1:0]       i_data_in,
   input  logic                    i_wr_en,
   input  logic                    i_rd_en,
   output logic [DATA_W-1:0]       o_data_out,
   output logic                    o_rd_valid,
   output logic                    o_full,
   output logic                    o_empty,
   output logic                    o_almost_full,
   output logic                    o_almost_empty,
   output logic [$clog2(DEPTH):0]  o_level,
   output logic                    o_overflow,
   output logic                    o_underflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam logic [LW-1:0] FULL_L = LW'(DEPTH);
   localparam logic [LW-1:0] AF_L   = LW'(AF_THRESH);
   localparam logic [LW-1:0] AE_L   = LW'(AE_THRESH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [LW-1:0]     r_level;
   logic              r_full;
   logic              r_empty;
   logic              r_af;
   logic              r_ae;
   logic              r_ovf;
   logic              r_udf;
`ifndef UART_FIFO_FWFT_EN
   logic [DATA_W-1:0] r_data_out;
   logic              r_rd_valid;
`endif

   logic              w_wr_acc;
   logic              w_rd_acc;
   logic [LW-1:0]     w_level_nxt;

   // Acceptance uses the registered pre-edge flags: no bypass when full or empty.
   assign w_wr_acc = i_wr_en & ~r_full;
   assign w_rd_acc = i_rd_en & ~r_empty;

   always_comb begin
      w_level_nxt = r_level;
      if (w_wr_acc && !w_rd_acc) begin
         w_level_nxt = r_level + LW'(1);
      end else if (!w_wr_acc && w_rd_acc) begin
         w_level_nxt = r_level - LW'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst && !i_clr && w_wr_acc) begin
         r_mem[r_wr_ptr] <= i_data_in;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_full     <= 1'b0;
         r_empty    <= 1'b1;
         r_af       <= (AF_THRESH == 0);
         r_ae       <= 1'b1;
         r_ovf      <= 1'b0;
         r_udf      <= 1'b0;
`ifndef UART_FIFO_FWFT_EN
         r_data_out <= '0;
         r_rd_valid <= 1'b0;
`endif
      end else if (i_clr) begin
         // Flush keeps the sticky errors and the last output word.
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_full     <= 1'b0;
         r_empty    <= 1'b1;
         r_af       <= (AF_THRESH == 0);
         r_ae       <= 1'b1;
`ifndef UART_FIFO_FWFT_EN
         r_rd_valid <= 1'b0;
`endif
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_rd_acc) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_level <= w_level_nxt;
         r_full  <= (w_level_nxt == FULL_L);
         r_empty <= (w_level_nxt == '0);
         r_af    <= (w_level_nxt >= AF_L);
         r_ae    <= (w_level_nxt <= AE_L);
         if (i_wr_en && r_full) begin
            r_ovf <= 1'b1;
         end
         if (i_rd_en && r_empty) begin
            r_udf <= 1'b1;
         end
`ifndef UART_FIFO_FWFT_EN
         r_rd_valid <= w_rd_acc;
         if (w_rd_acc) begin
            r_data_out <= r_mem[r_rd_ptr];
         end
`endif
      end
   end

`ifdef UART_FIFO_FWFT_EN
   assign o_data_out = r_mem[r_rd_ptr];
   assign o_rd_valid = ~r_empty;
`else
   assign o_data_out = r_data_out;
   assign o_rd_valid = r_rd_valid;
`endif

   assign o_full         = r_full;
   assign o_empty        = r_empty;
   assign o_almost_full  = r_af;
   assign o_almost_empty = r_ae;
   assign o_level        = r_level;
   assign o_overflow     = r_ovf;
   assign o_underflow    = r_udf;

endmodule

// File: tb/tb_uart_fifo_param.sv
// Directed self-checking bench for uart_fifo_param (DATA_W=8, DEPTH=16, AF=14, AE=2).
// Covers the registered-read build, or the fall-through build when UART_FIFO_FWFT_EN is defined.
module tb_uart_fifo_param;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       clr = 1'b0;
   logic       wr_en = 1'b0;
   logic       rd_en = 1'b0;
   logic [7:0] din = '0;
   logic [7:0] dout;
   logic       rd_valid;
   logic       full;
   logic       empty;
   logic       af;
   logic       ae;
   logic [4:0] level;
   logic       ovf;
   logic       udf;

   int total = 0;
   int bad   = 0;

   uart_fifo_param #(
      .DATA_W    (8),
      .DEPTH     (16),
      .AF_THRESH (14),
      .AE_THRESH (2)
   ) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_clr          (clr),
      .i_data_in      (din),
      .i_wr_en        (wr_en),
      .i_rd_en        (rd_en),
      .o_data_out     (dout),
      .o_rd_valid     (rd_valid),
      .o_full         (full),
      .o_empty        (empty),
      .o_almost_full  (af),
      .o_almost_empty (ae),
      .o_level        (level),
      .o_overflow     (ovf),
      .o_underflow    (udf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Level and the four level-derived flags against the bench's own threshold model.
   task automatic chk_lvl(input string tag, input int l);
      chk({tag, ".level"}, 32'(level), 32'(l));
      chk({tag, ".full"}, 32'(full), 32'(l == 16));
      chk({tag, ".empty"}, 32'(empty), 32'(l == 0));
      chk({tag, ".af"}, 32'(af), 32'(l >= 14));
      chk({tag, ".ae"}, 32'(ae), 32'(l <= 2));
   endtask

   // One clock: drive inputs, take the edge, sample 1 time unit later, release inputs.
   task automatic tick(input logic w, input logic [7:0] d, input logic r,
                       input logic c, input logic rs);
      wr_en = w; din = d; rd_en = r; clr = c; rst = rs;
      @(posedge clk);
      #1;
      wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0; rst = 1'b0; din = '0;
   endtask

   initial begin
`ifndef UART_FIFO_FWFT_EN
      // 1: reset state, then three writes and three reads.
      tick(0, 8'h00, 0, 0, 1);
      chk_lvl("rst", 0);
      chk("rst.rd_valid", 32'(rd_valid), 0);
      chk("rst.dout", 32'(dout), 0);
      chk("rst.ovf", 32'(ovf), 0);
      chk("rst.udf", 32'(udf), 0);
      tick(1, 8'h11, 0, 0, 0); chk_lvl("t1.w0", 1);
      tick(1, 8'h22, 0, 0, 0); chk_lvl("t1.w1", 2);
      tick(1, 8'h33, 0, 0, 0); chk_lvl("t1.w2", 3);
      chk("t1.rv_idle", 32'(rd_valid), 0);
      tick(0, 8'h00, 1, 0, 0); chk_lvl("t1.r0", 2);
      chk("t1.r0.dout", 32'(dout), 32'h11); chk("t1.r0.rv", 32'(rd_valid), 1);
      tick(0, 8'h00, 1, 0, 0); chk_lvl("t1.r1", 1);
      chk("t1.r1.dout", 32'(dout), 32'h22); chk("t1.r1.rv", 32'(rd_valid), 1);
      tick(0, 8'h00, 1, 0, 0); chk_lvl("t1.r2", 0);
      chk("t1.r2.dout", 32'(dout), 32'h33); chk("t1.r2.rv", 32'(rd_valid), 1);
      tick(0, 8'h00, 0, 0, 0);
      chk("t1.hold.rv", 32'(rd_valid), 0); chk("t1.hold.dout", 32'(dout), 32'h33);

      // 2: fill to full, overflow attempt, drain across the pointer wrap.
      for (int i = 0; i < 16; i++) begin
         tick(1, 8'(i), 0, 0, 0);
         chk_lvl($sformatf("t2.w%0d", i), i + 1);
      end
      tick(1, 8'hAA, 0, 0, 0);
      chk_lvl("t2.ovw", 16);
      chk("t2.ovf", 32'(ovf), 1);
      for (int i = 0; i < 16; i++) begin
         tick(0, 8'h00, 1, 0, 0);
         chk($sformatf("t2.r%0d.dout", i), 32'(dout), 32'(i));
         chk($sformatf("t2.r%0d.rv", i), 32'(rd_valid), 1);
         chk_lvl($sformatf("t2.r%0d", i), 15 - i);
      end
      chk("t2.udf", 32'(udf), 0);

      // 3: simultaneous read/write at level 5, then both at level 0.
      tick(0, 8'h00, 0, 0, 1);
      chk("t3.rst.ovf", 32'(ovf), 0);
      for (int i = 0; i < 5; i++) tick(1, 8'h40 + 8'(i), 0, 0, 0);
      chk_lvl("t3.pre", 5);
      for (int k = 0; k < 10; k++) begin
         tick(1, 8'h50 + 8'(k), 1, 0, 0);
         chk($sformatf("t3.rw%0d.dout", k), 32'(dout),
             (k < 5) ? 32'h40 + 32'(k) : 32'h50 + 32'(k - 5));
         chk($sformatf("t3.rw%0d.lvl", k), 32'(level), 5);
      end
      for (int i = 0; i < 5; i++) begin
         tick(0, 8'h00, 1, 0, 0);
         chk($sformatf("t3.d%0d.dout", i), 32'(dout), 32'h55 + 32'(i));
         chk_lvl($sformatf("t3.d%0d", i), 4 - i);
      end
      tick(1, 8'h77, 1, 0, 0);
      chk_lvl("t3.both0", 1);
      chk("t3.both0.udf", 32'(udf), 1);
      chk("t3.both0.rv", 32'(rd_valid), 0);
      tick(0, 8'h00, 1, 0, 0);
      chk("t3.last.dout", 32'(dout), 32'h77);

      // 4: underflow from reset survives flush, clears on reset.
      tick(0, 8'h00, 0, 0, 1);
      tick(0, 8'h00, 1, 0, 0);
      chk("t4.udf", 32'(udf), 1); chk("t4.rv", 32'(rd_valid), 0); chk_lvl("t4", 0);
      tick(0, 8'h00, 0, 1, 0);
      chk("t4.clr.udf", 32'(udf), 1);
      tick(0, 8'h00, 0, 0, 1);
      chk("t4.rst.udf", 32'(udf), 0);

      // 5: flush with concurrent write keeps overflow; reset mid-drain.
      for (int i = 0; i < 17; i++) tick(1, 8'(i), 0, 0, 0);
      chk("t5.ovf", 32'(ovf), 1);
      tick(0, 8'h00, 0, 1, 0);
      chk_lvl("t5.clr0", 0);
      for (int i = 0; i < 7; i++) tick(1, 8'h60 + 8'(i), 0, 0, 0);
      chk_lvl("t5.pre", 7);
      tick(1, 8'hEE, 1, 1, 0);
      chk_lvl("t5.clr", 0);
      chk("t5.clr.ovf", 32'(ovf), 1);
      chk("t5.clr.udf", 32'(udf), 0);
      chk("t5.clr.rv", 32'(rd_valid), 0);
      tick(1, 8'h61, 0, 0, 0);
      tick(0, 8'h00, 1, 0, 0);
      chk("t5.nostore.dout", 32'(dout), 32'h61);
      chk_lvl("t5.nostore", 0);
      tick(1, 8'hC1, 0, 0, 0);
      tick(1, 8'hC2, 0, 0, 0);
      tick(1, 8'hC3, 0, 0, 0);
      tick(0, 8'h00, 1, 0, 0);
      chk("t5.drain.dout", 32'(dout), 32'hC1);
      tick(0, 8'h00, 1, 1, 0);
      chk("t5.clr_rd.rv", 32'(rd_valid), 0);
      chk("t5.clr_rd.dout", 32'(dout), 32'hC1);
      tick(1, 8'hD1, 0, 0, 0);
      tick(1, 8'hD2, 0, 0, 0);
      tick(0, 8'h00, 1, 0, 0);
      tick(0, 8'h00, 1, 0, 1);
      chk_lvl("t5.rst", 0);
      chk("t5.rst.rv", 32'(rd_valid), 0);
      chk("t5.rst.dout", 32'(dout), 0);
      chk("t5.rst.ovf", 32'(ovf), 0);
      chk("t5.rst.udf", 32'(udf), 0);
`else
      // 6: fall-through presentation and pop.
      tick(0, 8'h00, 0, 0, 1);
      chk_lvl("f.rst", 0);
      chk("f.rst.rv", 32'(rd_valid), 0);
      tick(1, 8'h5A, 0, 0, 0);
      chk("f.w.dout", 32'(dout), 32'h5A); chk("f.w.rv", 32'(rd_valid), 1);
      tick(0, 8'h00, 0, 0, 0);
      chk("f.hold.dout", 32'(dout), 32'h5A); chk_lvl("f.hold", 1);
      tick(0, 8'h00, 1, 0, 0);
      chk_lvl("f.pop", 0); chk("f.pop.rv", 32'(rd_valid), 0);
      tick(1, 8'hA1, 0, 0, 0);
      tick(1, 8'hA2, 0, 0, 0);
      chk("f.two.dout", 32'(dout), 32'hA1);
      tick(0, 8'h00, 1, 0, 0);
      chk("f.next.dout", 32'(dout), 32'hA2); chk("f.next.rv", 32'(rd_valid), 1);
      tick(0, 8'h00, 1, 0, 0);
      chk_lvl("f.end", 0);
      tick(0, 8'h00, 1, 0, 0);
      chk("f.udf", 32'(udf), 1);
      chk("f.udf.rv", 32'(rd_valid), 0);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
